// File: rtl/prescaler_pkg.sv
// Shared encodings and the reset-default divisor helper for the prescaler bank.
package prescaler_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reload value that yields hz pulses per second from a clk_hz clock.
  function automatic longint unsigned div_default(input longint unsigned clk_hz,
                                                  input longint unsigned hz);
    return (clk_hz / hz) - 64'd1;
  endfunction

endpackage

// File: rtl/prescaler_channel.sv
// One prescaler channel: counter, shadow/active divisor, mode and IDLE/RUN FSM.
// The pulse and state are decoded from registers only.
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int             B       = 27,
  parameter logic [B-1:0]   DIV_RST = '0
) (
  input  logic         i_CLK,
  input  logic         i_Reset,
  input  logic         en,
  input  logic         trig,
  input  logic         sync,
  input  logic         we,
  input  logic [B-1:0] div,
  input  logic         wmode,
  output logic         ceo,
  output state_t       state
`ifdef PRESCALER_READBACK_EN
  ,
  output logic [B-1:0] q_out,
  output logic [B-1:0] dact_out
`endif
);

  logic [B-1:0] q, q_nxt;
  logic [B-1:0] dsh, dact, dact_nxt;
  logic         mode;
  state_t       state_q, state_nxt;
  logic         terminal;
  logic         load;

  assign terminal = (state_q == ST_RUN) && (q == dact);
  // A write landing on a load edge is forwarded so it takes effect at once.
  assign load     = (state_q == ST_IDLE) || terminal || sync;
  assign dact_nxt = load ? (we ? div : dsh) : dact;

  assign ceo   = terminal;
  assign state = state_q;

`ifdef PRESCALER_READBACK_EN
  assign q_out    = q;
  assign dact_out = dact;
`endif

  // Priority: disable > sync > retrigger > wrap/increment.
  always_comb begin
    q_nxt     = q;
    state_nxt = state_q;
    if (!en) begin
      state_nxt = ST_IDLE;
      q_nxt     = '0;
    end else if (state_q == ST_IDLE) begin
      if ((mode == MODE_PERIODIC) || trig) begin
        state_nxt = ST_RUN;
        q_nxt     = '0;
      end
    end else if (sync) begin
      q_nxt = '0;
    end else if (trig && (mode == MODE_ONESHOT)) begin
      q_nxt = '0;
    end else if (terminal) begin
      q_nxt = '0;
      if (mode == MODE_ONESHOT) begin
        state_nxt = ST_IDLE;
      end
    end else begin
      q_nxt = q + B'(1);
    end
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      q       <= '0;
      dsh     <= DIV_RST;
      dact    <= DIV_RST;
      mode    <= MODE_PERIODIC;
      state_q <= ST_IDLE;
    end else begin
      q       <= q_nxt;
      dact    <= dact_nxt;
      state_q <= state_nxt;
      if (we) begin
        dsh  <= div;
        mode <= wmode;
      end
    end
  end

endmodule

// File: rtl/prescaler_bank.sv
// N-channel programmable clock-enable generator with global phase sync.
// Optional readback of the addressed channel's Q and Dact: PRESCALER_READBACK_EN.
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int          N      = 4,
  parameter int          B      = 27,
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned HZ     = 1
) (
  input  logic                                  i_CLK,
  input  logic                                  i_Reset,
  input  logic [N-1:0]                          i_En,
  input  logic [N-1:0]                          i_Trig,
  input  logic                                  i_Sync,
  // i_WE is a single-cycle strobe: the addressed channel captures i_Div/i_Mode
  // at that edge; there is no back-pressure.
  input  logic                                  i_WE,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  i_Addr,
  input  logic [B-1:0]                          i_Div,
  input  logic                                  i_Mode,
  output logic [N-1:0]                          o_CEO,
  output logic [N-1:0]                          o_Busy
`ifdef PRESCALER_READBACK_EN
  ,
  output logic [B-1:0]                          o_Count,
  output logic [B-1:0]                          o_DivAct
`endif
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam longint unsigned DIV_DEFAULT_L = div_default(CLK_HZ, HZ);
  localparam logic [B-1:0] DIV_DEFAULT = B'(DIV_DEFAULT_L);

  if (DIV_DEFAULT_L >= (64'd1 << B)) begin : g_div_range
    $error("prescaler_bank: CLK_HZ/HZ-1 does not fit in B bits");
  end

  logic [N-1:0] we_c;
  state_t       ch_state [N];

`ifdef PRESCALER_READBACK_EN
  logic [B-1:0] q_arr    [N];
  logic [B-1:0] dact_arr [N];
`endif

  for (genvar c = 0; c < N; c++) begin : g_ch
    assign we_c[c]   = i_WE && (i_Addr == AW'(c));
    assign o_Busy[c] = (ch_state[c] == ST_RUN);

    prescaler_channel #(
      .B       (B),
      .DIV_RST (DIV_DEFAULT)
    ) u_ch (
      .i_CLK   (i_CLK),
      .i_Reset (i_Reset),
      .en      (i_En[c]),
      .trig    (i_Trig[c]),
      .sync    (i_Sync),
      .we      (we_c[c]),
      .div     (i_Div),
      .wmode   (i_Mode),
      .ceo     (o_CEO[c]),
      .state   (ch_state[c])
`ifdef PRESCALER_READBACK_EN
      ,
      .q_out    (q_arr[c]),
      .dact_out (dact_arr[c])
`endif
    );
  end

`ifdef PRESCALER_READBACK_EN
  localparam int AWP = AW + 1;

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      o_Count  <= '0;
      o_DivAct <= '0;
    end else if ({1'b0, i_Addr} < AWP'(N)) begin
      o_Count  <= q_arr[i_Addr];
      o_DivAct <= dact_arr[i_Addr];
    end else begin
      o_Count  <= '0;
      o_DivAct <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_prescaler_bank.sv
// Directed bench for prescaler_bank with N=4, B=8, CLK_HZ=10, HZ=1 (default D=9).
module tb_prescaler_bank;

  logic       i_CLK = 1'b0;
  logic       i_Reset;
  logic [3:0] i_En;
  logic [3:0] i_Trig;
  logic       i_Sync;
  logic       i_WE;
  logic [1:0] i_Addr;
  logic [7:0] i_Div;
  logic       i_Mode;
  logic [3:0] o_CEO;
  logic [3:0] o_Busy;

  int n_tests = 0;
  int n_fail  = 0;

  prescaler_bank #(
    .N      (4),
    .B      (8),
    .CLK_HZ (10),
    .HZ     (1)
  ) dut (
    .i_CLK   (i_CLK),
    .i_Reset (i_Reset),
    .i_En    (i_En),
    .i_Trig  (i_Trig),
    .i_Sync  (i_Sync),
    .i_WE    (i_WE),
    .i_Addr  (i_Addr),
    .i_Div   (i_Div),
    .i_Mode  (i_Mode),
    .o_CEO   (o_CEO),
    .o_Busy  (o_Busy)
  );

  // Clock and reset
  always #5 i_CLK = ~i_CLK;

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (o_CEO !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ceo: got %b expected %b", o_CEO, 4'b0000);
    end
    n_tests++;
    if (o_Busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected %b", o_Busy, 4'b0000);
    end
    i_Reset = 1'b0;
    tick();
    n_tests++;
    if ((o_CEO !== 4'b0000) || (o_Busy !== 4'b0000)) begin
      n_fail++;
      $display("FAIL post_reset_idle: ceo %b busy %b expected 0000 0000", o_CEO, o_Busy);
    end
  endtask

  task automatic test_default_rate();
    logic [3:0] exp_ceo;
    i_En = 4'b0001;
    for (int n = 1; n <= 30; n++) begin
      tick();
      exp_ceo = ((n % 10) == 0) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (o_CEO !== exp_ceo) begin
        n_fail++;
        $display("FAIL default_rate_ceo n=%0d: got %b expected %b", n, o_CEO, exp_ceo);
      end
      n_tests++;
      if (o_Busy !== 4'b0001) begin
        n_fail++;
        $display("FAIL default_rate_busy n=%0d: got %b expected %b", n, o_Busy, 4'b0001);
      end
    end
    i_En = 4'b0000;
    tick();
    n_tests++;
    if ((o_CEO !== 4'b0000) || (o_Busy !== 4'b0000)) begin
      n_fail++;
      $display("FAIL default_rate_disable: ceo %b busy %b expected 0000 0000", o_CEO, o_Busy);
    end
  endtask

  task automatic test_div_update();
    logic       pulse;
    logic [3:0] exp_ceo;
    i_WE   = 1'b1;
    i_Addr = 2'd1;
    i_Div  = 8'd3;
    i_Mode = 1'b0;
    i_En   = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      tick();
      pulse   = (n <= 12) ? ((n % 4) == 0) : ((n % 2) == 0);
      exp_ceo = {2'b00, pulse, 1'b0};
      n_tests++;
      if (o_CEO !== exp_ceo) begin
        n_fail++;
        $display("FAIL div_update_ceo n=%0d: got %b expected %b", n, o_CEO, exp_ceo);
      end
      n_tests++;
      if (o_Busy !== 4'b0010) begin
        n_fail++;
        $display("FAIL div_update_busy n=%0d: got %b expected %b", n, o_Busy, 4'b0010);
      end
      i_WE = (n == 9);
      if (n == 9) i_Div = 8'd1;
    end
    i_WE = 1'b0;
    i_En = 4'b0000;
    tick();
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_ceo;
    logic [3:0] exp_busy;
    i_WE   = 1'b1;
    i_Addr = 2'd2;
    i_Div  = 8'd5;
    i_Mode = 1'b1;
    tick();
    i_WE = 1'b0;
    i_En = 4'b0100;
    tick();
    n_tests++;
    if (o_Busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL oneshot_armed_idle: got %b expected %b", o_Busy, 4'b0000);
    end
    i_Trig = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      i_Trig   = 4'b0000;
      exp_busy = (k <= 6) ? 4'b0100 : 4'b0000;
      exp_ceo  = (k == 6) ? 4'b0100 : 4'b0000;
      n_tests++;
      if ((o_CEO !== exp_ceo) || (o_Busy !== exp_busy)) begin
        n_fail++;
        $display("FAIL oneshot k=%0d: ceo %b busy %b expected %b %b", k, o_CEO, o_Busy, exp_ceo, exp_busy);
      end
    end
    i_Trig = 4'b0100;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_busy = (k <= 9) ? 4'b0100 : 4'b0000;
      exp_ceo  = (k == 9) ? 4'b0100 : 4'b0000;
      n_tests++;
      if ((o_CEO !== exp_ceo) || (o_Busy !== exp_busy)) begin
        n_fail++;
        $display("FAIL oneshot_retrig k=%0d: ceo %b busy %b expected %b %b", k, o_CEO, o_Busy, exp_ceo, exp_busy);
      end
      i_Trig = (k == 3) ? 4'b0100 : 4'b0000;
    end
    i_En = 4'b0000;
    tick();
    i_Trig = 4'b0100;
    tick();
    i_Trig = 4'b0000;
    n_tests++;
    if (o_Busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL oneshot_trig_disabled: got %b expected %b", o_Busy, 4'b0000);
    end
  endtask

  task automatic test_sync();
    logic [3:0] exp_ceo;
    i_WE   = 1'b1;
    i_Mode = 1'b0;
    i_Addr = 2'd0;
    i_Div  = 8'd3;
    tick();
    i_Addr = 2'd1;
    i_Div  = 8'd7;
    tick();
    i_WE = 1'b0;
    i_En = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_ceo = (k == 4) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (o_CEO !== exp_ceo) begin
        n_fail++;
        $display("FAIL sync_pre k=%0d: got %b expected %b", k, o_CEO, exp_ceo);
      end
      if (k == 2) i_En = 4'b0011;
    end
    i_Sync = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      tick();
      i_Sync  = 1'b0;
      exp_ceo = {2'b00, ((s % 8) == 0), ((s % 4) == 0)};
      n_tests++;
      if ((o_CEO !== exp_ceo) || (o_Busy !== 4'b0011)) begin
        n_fail++;
        $display("FAIL sync s=%0d: ceo %b busy %b expected %b %b", s, o_CEO, o_Busy, exp_ceo, 4'b0011);
      end
    end
    i_En = 4'b0000;
    tick();
  endtask

  task automatic test_div_zero();
    i_WE   = 1'b1;
    i_Addr = 2'd3;
    i_Div  = 8'd0;
    i_Mode = 1'b0;
    tick();
    i_WE = 1'b0;
    i_En = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++;
      if (o_CEO !== 4'b1000) begin
        n_fail++;
        $display("FAIL div_zero_ceo k=%0d: got %b expected %b", k, o_CEO, 4'b1000);
      end
    end
    i_En = 4'b0000;
    tick();
    n_tests++;
    if ((o_CEO !== 4'b0000) || (o_Busy !== 4'b0000)) begin
      n_fail++;
      $display("FAIL div_zero_disable: ceo %b busy %b expected 0000 0000", o_CEO, o_Busy);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_ceo;
    i_En = 4'b0001;
    tick();
    tick();
    n_tests++;
    if (o_Busy !== 4'b0001) begin
      n_fail++;
      $display("FAIL areset_pre_busy: got %b expected %b", o_Busy, 4'b0001);
    end
    #3;
    i_Reset = 1'b1;
    #1;
    n_tests++;
    if ((o_CEO !== 4'b0000) || (o_Busy !== 4'b0000)) begin
      n_fail++;
      $display("FAIL areset_immediate: ceo %b busy %b expected 0000 0000", o_CEO, o_Busy);
    end
    #2;
    i_Reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_ceo = (n == 10) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (o_CEO !== exp_ceo) begin
        n_fail++;
        $display("FAIL areset_default_div n=%0d: got %b expected %b", n, o_CEO, exp_ceo);
      end
    end
    i_En = 4'b0000;
    tick();
  endtask

  initial begin
    i_Reset = 1'b1;
    i_En    = 4'b0000;
    i_Trig  = 4'b0000;
    i_Sync  = 1'b0;
    i_WE    = 1'b0;
    i_Addr  = 2'd0;
    i_Div   = 8'd0;
    i_Mode  = 1'b0;
    repeat (3) @(posedge i_CLK);
    #1;
    test_reset();
    test_default_rate();
    test_div_update();
    test_oneshot();
    test_sync();
    test_div_zero();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
